// File: rtl/cla_slice_sequencer.sv
// Sequences a WIDTH-bit add through a shared external 4-bit CLA slice, one nibble per cycle.
// Optional signed overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_slice_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;
  logic             accept_c;
  logic             last_c;

  assign accept_c = (state_q == S_IDLE) && in_valid;
  assign last_c   = (idx_q == IDX_W'(NIB - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and slice drive; slice ports are zero outside RUN
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        busy      = 1'b1;
        slice_a   = a_q[4*idx_q +: 4];
        slice_b   = b_q[4*idx_q +: 4];
        slice_cin = carry_q;
      end
      S_DONE:  busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values; carry between nibbles only ever passes through carry_q
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    if (accept_c) begin
      a_d     = in_a;
      b_d     = in_b;
      carry_d = in_cin;
      idx_d   = '0;
      sum_d   = '0;
    end else if (state_q == S_RUN) begin
      sum_d[4*idx_q +: 4] = slice_sum;
      carry_d             = slice_cout;
      if (last_c) begin
        idx_d   = '0;
        cout_d  = slice_cout;
        valid_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (state_q == S_DONE && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_valid = valid_q;

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands agree in sign but the result MSB does not
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last_c)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Self-checking bench for cla_slice_sequencer with the CLA slice modelled as a 4-bit adder.
module tb_cla_slice_sequencer;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef CLA_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int total = 0;
  int bad   = 0;

  cla_slice_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_sum (slice_sum),
    .slice_cout(slice_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // Combinational 4-bit adder standing in for the CLA slice
  assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, per-nibble slice checks, result, backpressure, release
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input bit poke);
    logic [W:0] full;
    int         mask;
    int         part;
    logic       exp_ovf;
    full    = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    tick();
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = 1'($urandom);
    for (int k = 0; k < int'(NIB); k++) begin
      mask = (1 << (4 * k)) - 1;
      part = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
      chk("slice_a",   32'(slice_a),   32'((int'(a) >> (4 * k)) & 15));
      chk("slice_b",   32'(slice_b),   32'((int'(b) >> (4 * k)) & 15));
      chk("slice_cin", 32'(slice_cin), 32'((part >> (4 * k)) & 1));
      chk("run_valid", 32'(out_valid), 32'd0);
      chk("run_busy",  32'(busy),      32'd1);
      chk("run_ready", 32'(in_ready),  32'd0);
      tick();
    end
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("out_sum",       32'(out_sum),   32'(full[W-1:0]));
    chk("out_cout",      32'(out_cout),  32'(full[W]));
`ifdef CLA_SEQ_OVF_EN
    chk("out_ovf",       32'(out_ovf),   32'(exp_ovf));
`endif
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
      end
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum",   32'(out_sum),   32'(full[W-1:0]));
      chk("hold_cout",  32'(out_cout),  32'(full[W]));
      chk("hold_ready", 32'(in_ready),  32'd0);
      chk("hold_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_ready", 32'(in_ready),  32'd1);
    chk("rel_busy",  32'(busy),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_cout",  32'(out_cout),  32'd0);
    chk("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    #9 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 5, 1'b1);

    // Mid-RUN asynchronous abort
    in_valid = 1'b1;
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    in_cin   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_sum",   32'(out_sum),   32'd0);
    chk("abort_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h0F0F, 16'h0101, 1'b0, 1, 1'b0);

    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands on one shared external 4-bit carry-lookahead adder slice.
- Processes one nibble per cycle, least significant first, and registers the carry between nibbles.
- Sits between a valid/ready requester and the 4-bit CLA slice, and drives the slice operand and carry ports directly.
- Returns the full sum and carry-out on a valid/ready result port.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of slice passes (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid and in_ready are both 1.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to nibble 0.
- slice_a  output  4  A nibble driven to the CLA slice.
- slice_b  output  4  B nibble driven to the CLA slice.
- slice_cin  output  1  carry driven to the CLA slice.
- slice_sum  input  4  combinational sum returned by the slice.
- slice_cout  input  1  combinational carry-out returned by the slice.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_sum  output  WIDTH  registered sum.
- out_cout  output  1  registered carry-out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx, a_reg, b_reg, carry_reg, out_sum, out_cout = 0.
  - out_valid=0, busy=0; in_ready=1 once rst_n=1.
- State machine:
  - IDLE:
    - in_ready=1, busy=0.
    - On in_valid&&in_ready: latch in_a→a_reg, in_b→b_reg, in_cin→carry_reg; idx=0; clear out_sum; go to RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Drive slice_a=a_reg[4*idx+:4], slice_b=b_reg[4*idx+:4], slice_cin=carry_reg.
    - At each edge: out_sum[4*idx+:4]<=slice_sum; carry_reg<=slice_cout; idx<=idx+1.
    - On the edge where idx==NIB-1: out_cout<=slice_cout, out_valid<=1, state→DONE, idx→0.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_sum and out_cout held stable until out_valid&&out_ready, then out_valid<=0 and state→IDLE.
- Slice ports outside RUN: slice_a=0, slice_b=0, slice_cin=0. The slice is never driven with stale operands.
- Timing:
  - The slice is combinational, so the controller samples slice_sum/slice_cout in the same cycle it drives them.
  - Latency: out_valid rises exactly NIB cycles after the accept edge.
  - Minimum issue interval is NIB+2 cycles: no accept in DONE or in the handshake cycle.
- Inputs during RUN/DONE: in_a, in_b and in_cin are ignored; a_reg/b_reg do not change.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1).
- Carry chain: carry from nibble k feeds nibble k+1 only via carry_reg, with no combinational path between passes.
- Reset mid-operation: abort immediately; partial sum cleared; state=IDLE; no out_valid pulse.
- out_ready asserted while out_valid=0 has no effect.
- idx width is clog2(NIB); idx never exceeds NIB-1.

Optional Feature:
- Macro: CLA_SEQ_OVF_EN.
- Defined:
  - Adds output out_ovf (1 bit), the signed two's-complement overflow flag.
  - Registered on the final RUN edge as (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (slice_sum[3]!=a_reg[WIDTH-1]).
  - Reset value 0; held with out_sum through DONE.
- Not defined: port absent; no extra logic.

Test Plan (WIDTH=16, bench models the slice as a 4-bit adder):
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle.
  - Required: out_valid, out_sum, out_cout, busy and slice_* go 0 immediately (async); in_ready=1 after release.
- Nominal add:
  - Stimulus: in_a=0x1234, in_b=0x4321, in_cin=0.
  - Required: slice_a sequence 4,3,2,1 on consecutive cycles; out_valid exactly 4 cycles after accept; out_sum=0x5555, out_cout=0.
- Full carry ripple:
  - Stimulus: in_a=0xFFFF, in_b=0x0001, in_cin=0.
  - Required: slice_cin sequence 0,1,1,1; out_sum=0x0000, out_cout=1.
- Carry-in and backpressure:
  - Stimulus: in_a=0x0000, in_b=0x0000, in_cin=1; hold out_ready=0 for 5 cycles; pulse in_valid with new operands during that time.
  - Required: out_sum=0x0001 held stable; out_valid stays 1; in_ready=0; new request not accepted; IDLE one cycle after out_ready=1.
- Reset mid-RUN:
  - Stimulus: drop rst_n after 2 RUN cycles of 0xAAAA+0x5555, then issue 0x0F0F+0x0101.
  - Required: no out_valid for the aborted op; second result 0x1010, out_cout=0.
- CLA_SEQ_OVF_EN:
  - Stimulus: 0x7FFF+0x0001.
  - Required: out_sum=0x8000, out_ovf=1.
  - Stimulus: 0x8000+0x8000.
  - Required: out_sum=0x0000, out_cout=1, out_ovf=1.
  - Stimulus: 0x1234+0x4321.
  - Required: out_ovf=0.
